rdma_pkt_classifier: RTL and testbench



---
 rtl/rdma_pkg.sv | 38 +++
 rtl/rdma_pkt_classifier_if.sv | 14 +
 rtl/rdma_hdr_match.sv | 37 +++
 rtl/rdma_pkt_classifier.sv | 197 +++++++++++++++++++
 tb/tb_rdma_pkt_classifier.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdma_pkg.sv
// Shared RDMA constants: header geometry, field offsets and classifier mode encodings.
// Imported by the RX classifier and any TX-side checker reusing rdma_hdr_match.
package rdma_pkg;

   localparam logic [15:0] RDMA_MAGIC    = 16'h0122;
   localparam int unsigned ETH_HDR_BYTES = 64;
   localparam int unsigned ETH_HDR_BITS  = ETH_HDR_BYTES * 8;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

   // Byte offsets from the start of the Ethernet frame
   localparam int unsigned PROT_OFS      = 23;
   localparam int unsigned UDP_DPORT_OFS = 36;
   localparam int unsigned MAGIC_OFS     = 42;

   typedef enum logic [1:0] {
      ModeFilter     = 2'd0,
      ModePassAll    = 2'd1,
      ModeDropAll    = 2'd2,
      ModeFilterRsvd = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StHdr,
      StFlush,
      StXfer,
      StDrop
   } state_e;

   // Reverse byte order so frame byte 0 lands in the MSBs (network order fields read MSB-first)
   function automatic logic [ETH_HDR_BITS-1:0] byte_swap_hdr(input logic [ETH_HDR_BITS-1:0] h);
      logic [ETH_HDR_BITS-1:0] s;
      for (int unsigned i = 0; i < ETH_HDR_BYTES; i++) begin
         s[ETH_HDR_BITS-1-8*i -: 8] = h[8*i +: 8];
      end
      return s;
   endfunction

endpackage

// File: rtl/rdma_pkt_classifier_if.sv
// AXI-Stream bundle used for the classifier's frame input and output.
interface rdma_axis_if #(
   parameter int unsigned DATA_WBITS = 512,
   parameter int unsigned DATA_WBYTS = DATA_WBITS / 8
);
   logic [DATA_WBITS-1:0] tdata;
   logic [DATA_WBYTS-1:0] tkeep;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rdma_hdr_match.sv
// Combinational RDMA header match: UDP, destination port in the list, and magic present.
// Takes the byte-swapped 64-byte header (frame byte 0 in the MSBs).
module rdma_hdr_match #(
   parameter int unsigned N_PORTS    = 2,
   parameter logic [15:0] RDMA_MAGIC = 16'h0122
) (
   input  logic [rdma_pkg::ETH_HDR_BITS-1:0] hdr_swapped_i,
   input  logic [N_PORTS*16-1:0]             ports_i,
   output logic                              is_rdma_o
);
   import rdma_pkg::*;

   localparam int unsigned ProtMsb  = ETH_HDR_BITS - 1 - 8 * PROT_OFS;
   localparam int unsigned DportMsb = ETH_HDR_BITS - 1 - 8 * UDP_DPORT_OFS;
   localparam int unsigned MagicMsb = ETH_HDR_BITS - 1 - 8 * MAGIC_OFS;

   logic [7:0]  prot;
   logic [15:0] dport;
   logic [15:0] magic;
   logic        port_hit;
   logic        unused_hdr;

   assign prot  = hdr_swapped_i[ProtMsb -: 8];
   assign dport = hdr_swapped_i[DportMsb -: 16];
   assign magic = hdr_swapped_i[MagicMsb -: 16];

   always_comb begin
      port_hit = 1'b0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (ports_i[16*k +: 16] == dport) port_hit = 1'b1;
      end
   end

   assign is_rdma_o  = (prot == IP_PROTO_UDP) && port_hit && (magic == RDMA_MAGIC);
   assign unused_hdr = ^hdr_swapped_i;

endmodule

// File: rtl/rdma_pkt_classifier.sv
// Classifies RX Ethernet frames as RDMA and forwards only those; the 64-byte header
// (1 or 2 beats) is buffered so the decision is known before the first beat leaves.
module rdma_pkt_classifier #(
   parameter int unsigned           DATA_WBITS = 512,
   parameter int unsigned           DATA_WBYTS = DATA_WBITS / 8,
   parameter int unsigned           N_PORTS    = 2,
   parameter logic [N_PORTS*16-1:0] RDMA_PORTS = {16'd32002, 16'd11111},
   parameter logic [15:0]           RDMA_MAGIC = rdma_pkg::RDMA_MAGIC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  mode,
   input  logic        clear_counters,
   rdma_axis_if.slave  axis_in,
   rdma_axis_if.master axis_out,
   output logic [31:0] pass_count,
   output logic [31:0] drop_count
);
   import rdma_pkg::*;

   localparam int unsigned HDR_BEATS = ETH_HDR_BITS / DATA_WBITS;
   localparam int unsigned CntW      = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam int unsigned BufDepth  = 1 << CntW;
   localparam logic [CntW-1:0] LastBeat = CntW'(HDR_BEATS - 1);

   state_e                state_q, state_d;
   logic [CntW-1:0]       hdr_cnt_q, hdr_cnt_d;
   logic [CntW-1:0]       out_cnt_q, out_cnt_d;
   logic [DATA_WBITS-1:0] hdr_buf_q [BufDepth];
   logic [DATA_WBITS-1:0] hdr_buf_d [BufDepth];
   logic [DATA_WBYTS-1:0] keep_q, keep_d;
   logic                  last_in_hdr_q, last_in_hdr_d;
   logic [1:0]            mode_q, mode_d;
   logic [31:0]           pass_cnt_q, pass_cnt_d;
   logic [31:0]           drop_cnt_q, drop_cnt_d;

   logic [ETH_HDR_BITS-1:0] hdr_flat;
   logic [ETH_HDR_BITS-1:0] hdr_swapped;
   logic                    is_rdma;
   logic [1:0]              mode_eff;
   logic                    pass_dec;
   logic                    pass_inc, drop_inc;
   logic                    in_tready, out_tvalid, out_tlast;
   logic [DATA_WBITS-1:0]   out_tdata;
   logic [DATA_WBYTS-1:0]   out_tkeep;

   // Final header slot comes straight from the bus so the decision lands on that beat
   always_comb begin
      hdr_flat = '0;
      for (int unsigned b = 0; b < HDR_BEATS; b++) begin
         hdr_flat[b*DATA_WBITS +: DATA_WBITS] =
            (b == HDR_BEATS - 1) ? axis_in.tdata : hdr_buf_q[CntW'(b)];
      end
   end

   assign hdr_swapped = byte_swap_hdr(hdr_flat);

   rdma_hdr_match #(
      .N_PORTS    (N_PORTS),
      .RDMA_MAGIC (RDMA_MAGIC)
   ) u_hdr_match (
      .hdr_swapped_i (hdr_swapped),
      .ports_i       (RDMA_PORTS),
      .is_rdma_o     (is_rdma)
   );

   assign mode_eff = (hdr_cnt_q == '0) ? mode : mode_q;

   always_comb begin
      case (mode_eff)
         ModePassAll: pass_dec = 1'b1;
         ModeDropAll: pass_dec = 1'b0;
         default:     pass_dec = is_rdma;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      hdr_cnt_d     = hdr_cnt_q;
      out_cnt_d     = out_cnt_q;
      hdr_buf_d     = hdr_buf_q;
      keep_d        = keep_q;
      last_in_hdr_d = last_in_hdr_q;
      mode_d        = mode_q;
      pass_inc      = 1'b0;
      drop_inc      = 1'b0;
      in_tready     = 1'b0;
      out_tvalid    = 1'b0;
      out_tdata     = hdr_buf_q[out_cnt_q];
      out_tkeep     = '1;
      out_tlast     = 1'b0;

      unique case (state_q)
         StHdr: begin
            in_tready = 1'b1;
            if (axis_in.tvalid) begin
               hdr_buf_d[hdr_cnt_q] = axis_in.tdata;
               if (hdr_cnt_q == '0) mode_d = mode;
               if (hdr_cnt_q == LastBeat) begin
                  hdr_cnt_d     = '0;
                  keep_d        = axis_in.tkeep;
                  last_in_hdr_d = axis_in.tlast;
                  if (pass_dec) begin
                     state_d   = StFlush;
                     out_cnt_d = '0;
                  end else begin
                     drop_inc = 1'b1;
                     state_d  = axis_in.tlast ? StHdr : StDrop;
                  end
               end else if (axis_in.tlast) begin
                  // Runt: frame ended before the header was complete
                  drop_inc  = 1'b1;
                  hdr_cnt_d = '0;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 1'b1;
               end
            end
         end
         StFlush: begin
            out_tvalid = 1'b1;
            if (out_cnt_q == LastBeat) begin
               out_tlast = last_in_hdr_q;
               if (last_in_hdr_q) out_tkeep = keep_q;
            end
            if (axis_out.tready) begin
               if (out_cnt_q == LastBeat) begin
                  pass_inc  = 1'b1;
                  out_cnt_d = '0;
                  state_d   = last_in_hdr_q ? StHdr : StXfer;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
         StXfer: begin
            out_tvalid = axis_in.tvalid;
            out_tdata  = axis_in.tdata;
            out_tkeep  = axis_in.tkeep;
            out_tlast  = axis_in.tlast;
            in_tready  = axis_out.tready;
            if (axis_in.tvalid && axis_out.tready && axis_in.tlast) state_d = StHdr;
         end
         StDrop: begin
            in_tready = 1'b1;
            if (axis_in.tvalid && axis_in.tlast) state_d = StHdr;
         end
         default: state_d = StHdr;
      endcase
   end

   // Clear beats a simultaneous increment; both counters stick at all-ones
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (clear_counters) begin
         pass_cnt_d = '0;
         drop_cnt_d = '0;
      end else begin
         if (pass_inc && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 32'd1;
         if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= StHdr;
         hdr_cnt_q     <= '0;
         out_cnt_q     <= '0;
         last_in_hdr_q <= 1'b0;
         mode_q        <= '0;
         pass_cnt_q    <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         hdr_cnt_q     <= hdr_cnt_d;
         out_cnt_q     <= out_cnt_d;
         last_in_hdr_q <= last_in_hdr_d;
         mode_q        <= mode_d;
         pass_cnt_q    <= pass_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      hdr_buf_q <= hdr_buf_d;
      keep_q    <= keep_d;
   end

   assign axis_in.tready  = in_tready & resetn;
   assign axis_out.tvalid = out_tvalid & resetn;
   assign axis_out.tdata  = out_tdata;
   assign axis_out.tkeep  = out_tkeep;
   assign axis_out.tlast  = out_tlast;
   assign pass_count      = pass_cnt_q;
   assign drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_rdma_pkt_classifier.sv
// Scoreboard bench: 512-bit and 256-bit classifier instances driven with directed frames.
module tb_rdma_pkt_classifier;
   import rdma_pkg::*;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } beat_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  mode_a, mode_b;
   logic        clr_a, clr_b;
   logic [31:0] pass_a, drop_a, pass_b, drop_b;
   bit          tog_a, tog_b;

   beat_t       exp_a[$];
   beat_t       exp_b[$];
   logic [31:0] exp_pass_cnt [2];
   logic [31:0] exp_drop_cnt [2];
   int          vectors     = 0;
   int          miscompares = 0;

   localparam logic [15:0] MAGIC = 16'h0122;

   always #5 clk = ~clk;

   rdma_axis_if #(.DATA_WBITS(512)) in_a ();
   rdma_axis_if #(.DATA_WBITS(512)) out_a ();
   rdma_axis_if #(.DATA_WBITS(256)) in_b ();
   rdma_axis_if #(.DATA_WBITS(256)) out_b ();

   rdma_pkt_classifier #(.DATA_WBITS(512)) dut_a (
      .clk            (clk),
      .resetn         (resetn),
      .mode           (mode_a),
      .clear_counters (clr_a),
      .axis_in        (in_a),
      .axis_out       (out_a),
      .pass_count     (pass_a),
      .drop_count     (drop_a)
   );

   rdma_pkt_classifier #(.DATA_WBITS(256)) dut_b (
      .clk            (clk),
      .resetn         (resetn),
      .mode           (mode_b),
      .clear_counters (clr_b),
      .axis_in        (in_b),
      .axis_out       (out_b),
      .pass_count     (pass_b),
      .drop_count     (drop_b)
   );

   // Frame byte i at bits [8i+:8]; fields written in network byte order
   function automatic logic [511:0] make_hdr(input int seed, input logic [7:0] prot,
                                             input logic [15:0] dport, input logic [15:0] magic);
      logic [511:0] h;
      for (int i = 0; i < 64; i++) h[8*i +: 8] = 8'(i * 7 + seed);
      h[8*23 +: 8] = prot;
      h[8*36 +: 8] = dport[15:8];
      h[8*37 +: 8] = dport[7:0];
      h[8*42 +: 8] = magic[15:8];
      h[8*43 +: 8] = magic[7:0];
      return h;
   endfunction

   function automatic logic [511:0] body(input int seed, input int i);
      logic [31:0] w;
      w = 32'(seed * 4096 + i * 17) ^ 32'h5A00_C3C3;
      return {16{w}};
   endfunction

   initial begin
      out_a.tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_a.tready = tog_a ? ~out_a.tready : 1'b1;
      end
   end

   initial begin
      out_b.tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_b.tready = tog_b ? ~out_b.tready : 1'b1;
      end
   end

   // Output monitors: pop on each handshake, and hold a stalled beat to its earlier value
   initial begin
      beat_t e;
      bit stall = 1'b0;
      logic [511:0] sdata;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               vectors++;
               if (!out_a.tvalid || out_a.tdata != sdata) begin
                  miscompares++;
                  $display("FAIL stall_a: valid=%0b data changed=%0b, want valid=1 unchanged",
                           out_a.tvalid, out_a.tdata != sdata);
               end
            end
            stall = out_a.tvalid && !out_a.tready;
            sdata = out_a.tdata;
            if (out_a.tvalid && out_a.tready) begin
               vectors++;
               if (exp_a.size() == 0) begin
                  miscompares++;
                  $display("FAIL beat_a: unexpected beat data=%h", out_a.tdata[63:0]);
               end else begin
                  e = exp_a.pop_front();
                  if (out_a.tdata != e.data || out_a.tkeep != e.keep || out_a.tlast != e.last) begin
                     miscompares++;
                     $display("FAIL beat_a: got data=%h keep=%h last=%0b want data=%h keep=%h last=%0b",
                              out_a.tdata[63:0], out_a.tkeep, out_a.tlast,
                              e.data[63:0], e.keep, e.last);
                  end
               end
            end
         end
      end
   end

   initial begin
      beat_t e;
      bit stall = 1'b0;
      logic [255:0] sdata;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               vectors++;
               if (!out_b.tvalid || out_b.tdata != sdata) begin
                  miscompares++;
                  $display("FAIL stall_b: valid=%0b data changed=%0b, want valid=1 unchanged",
                           out_b.tvalid, out_b.tdata != sdata);
               end
            end
            stall = out_b.tvalid && !out_b.tready;
            sdata = out_b.tdata;
            if (out_b.tvalid && out_b.tready) begin
               vectors++;
               if (exp_b.size() == 0) begin
                  miscompares++;
                  $display("FAIL beat_b: unexpected beat data=%h", out_b.tdata[63:0]);
               end else begin
                  e = exp_b.pop_front();
                  if (out_b.tdata != e.data[255:0] || out_b.tkeep != e.keep[31:0] ||
                      out_b.tlast != e.last) begin
                     miscompares++;
                     $display("FAIL beat_b: got data=%h keep=%h last=%0b want data=%h keep=%h last=%0b",
                              out_b.tdata[63:0], out_b.tkeep, out_b.tlast,
                              e.data[63:0], e.keep[31:0], e.last);
                  end
               end
            end
         end
      end
   end

   // w=0 drives the 512-bit instance, w=1 the 256-bit one; returns at posedge+1 after handshake
   task automatic drive_beat(input int w, input logic [511:0] d, input logic [63:0] k,
                             input logic l);
      bit done;
      done = 1'b0;
      if (w == 0) begin
         in_a.tdata = d; in_a.tkeep = k; in_a.tlast = l; in_a.tvalid = 1'b1;
      end else begin
         in_b.tdata = d[255:0]; in_b.tkeep = k[31:0]; in_b.tlast = l; in_b.tvalid = 1'b1;
      end
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         done = (w == 0) ? in_a.tready : in_b.tready;
         @(posedge clk); #1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL in_ready_%0d: tready=0 for 200 cycles, want 1", w);
      end
   endtask

   task automatic send_frame(input int w, input int seed, input logic [7:0] prot,
                             input logic [15:0] dport, input logic [15:0] magic,
                             input logic [1:0] m1, input logic [1:0] m2, input int nbeats,
                             input logic [63:0] last_keep, input bit exp_pass);
      logic [511:0] hdr, d, bd;
      logic [63:0]  k, kmask;
      beat_t        e;
      hdr   = make_hdr(seed, prot, dport, magic);
      kmask = (w == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      if (w == 0) mode_a = m1; else mode_b = m1;
      for (int i = 0; i < nbeats; i++) begin
         bd = body(seed, i);
         if (w == 0) d = (i == 0) ? hdr : bd;
         else if (i < 2) d = {256'b0, hdr[256*i +: 256]};
         else d = {256'b0, bd[255:0]};
         k = (i == nbeats - 1) ? (last_keep & kmask) : kmask;
         if (exp_pass) begin
            e.data = d; e.keep = k; e.last = (i == nbeats - 1);
            if (w == 0) exp_a.push_back(e); else exp_b.push_back(e);
         end
         drive_beat(w, d, k, i == nbeats - 1);
         if (i == 0) begin
            if (w == 0) mode_a = m2; else mode_b = m2;
         end
      end
      if (w == 0) begin in_a.tvalid = 1'b0; in_a.tlast = 1'b0; end
      else begin in_b.tvalid = 1'b0; in_b.tlast = 1'b0; end
      if (exp_pass) begin
         if (exp_pass_cnt[w] != '1) exp_pass_cnt[w] = exp_pass_cnt[w] + 1;
      end else begin
         if (exp_drop_cnt[w] != '1) exp_drop_cnt[w] = exp_drop_cnt[w] + 1;
      end
   endtask

   task automatic drain(input int w);
      int n;
      n = 0;
      while (((w == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_%0d: %0d beats still pending, want 0", w,
                  (w == 0) ? exp_a.size() : exp_b.size());
      end
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic check_counts(input int w, input string tag);
      logic [31:0] p, d;
      @(negedge clk);
      p = (w == 0) ? pass_a : pass_b;
      d = (w == 0) ? drop_a : drop_b;
      vectors++;
      if (p != exp_pass_cnt[w]) begin
         miscompares++;
         $display("FAIL %s pass_count: got %0d want %0d", tag, p, exp_pass_cnt[w]);
      end
      vectors++;
      if (d != exp_drop_cnt[w]) begin
         miscompares++;
         $display("FAIL %s drop_count: got %h want %h", tag, d, exp_drop_cnt[w]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_pass_cnt = '{default: '0};
      exp_drop_cnt = '{default: '0};
      resetn = 1'b0;
      mode_a = 2'd0; mode_b = 2'd0; clr_a = 1'b0; clr_b = 1'b0;
      in_a.tvalid = 1'b0; in_a.tlast = 1'b0; in_a.tdata = '0; in_a.tkeep = '0;
      in_b.tvalid = 1'b0; in_b.tlast = 1'b0; in_b.tdata = '0; in_b.tkeep = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out_a.tvalid || out_b.tvalid) begin
         miscompares++;
         $display("FAIL reset_tvalid: got a=%0b b=%0b want 0", out_a.tvalid, out_b.tvalid);
      end
      vectors++;
      if (in_a.tready || in_b.tready) begin
         miscompares++;
         $display("FAIL reset_tready: got a=%0b b=%0b want 0", in_a.tready, in_b.tready);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      vectors++;
      if (!in_a.tready || !in_b.tready) begin
         miscompares++;
         $display("FAIL hdr_tready: got a=%0b b=%0b want 1", in_a.tready, in_b.tready);
      end
      @(posedge clk); #1;
      check_counts(0, "reset_a");
      check_counts(1, "reset_b");

      // 512-bit: valid frame, port mismatch, header-only frame, reserved mode, bad magic
      send_frame(0, 1, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd0, 3, '1, 1'b1);
      drain(0);
      check_counts(0, "t1_a");
      send_frame(0, 2, 8'd17, 16'd5000, MAGIC, 2'd0, 2'd0, 3, '1, 1'b0);
      send_frame(0, 3, 8'd17, 16'd32002, MAGIC, 2'd0, 2'd0, 2, 64'h00FF_FFFF_FFFF_FFFF, 1'b1);
      drain(0);
      check_counts(0, "t2_a");
      send_frame(0, 4, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd0, 1, 64'h0000_0000_0000_0FFF, 1'b1);
      send_frame(0, 5, 8'd17, 16'd32002, MAGIC, 2'd3, 2'd3, 2, '1, 1'b1);
      send_frame(0, 6, 8'd17, 16'd11111, 16'h0123, 2'd0, 2'd0, 1, '1, 1'b0);
      drain(0);
      check_counts(0, "misc_a");

      // 256-bit: stalled output, runt, header-only frame, TCP
      tog_b = 1'b1;
      send_frame(1, 10, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd0, 4, '1, 1'b1);
      drain(1);
      tog_b = 1'b0;
      check_counts(1, "t3_b");
      send_frame(1, 11, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd0, 1, 64'hFFFF, 1'b0);
      send_frame(1, 12, 8'd17, 16'd32002, MAGIC, 2'd0, 2'd0, 3, '1, 1'b1);
      drain(1);
      check_counts(1, "t4_b");
      send_frame(1, 13, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd0, 2, 64'h00FF_FFFF, 1'b1);
      send_frame(1, 14, 8'd6, 16'd11111, MAGIC, 2'd0, 2'd0, 3, '1, 1'b0);
      drain(1);
      check_counts(1, "hdr_only_b");

      // Modes, including changes after the first header beat
      send_frame(1, 15, 8'd17, 16'd11111, MAGIC, 2'd2, 2'd2, 3, '1, 1'b0);
      send_frame(1, 16, 8'd6, 16'd11111, MAGIC, 2'd1, 2'd1, 3, '1, 1'b1);
      send_frame(1, 17, 8'd17, 16'd11111, MAGIC, 2'd2, 2'd0, 3, '1, 1'b0);
      send_frame(1, 18, 8'd17, 16'd11111, MAGIC, 2'd0, 2'd2, 3, '1, 1'b1);
      mode_b = 2'd0;
      drain(1);
      check_counts(1, "t5_b");

      // Saturation and clear-vs-increment on the 512-bit instance
      force dut_a.drop_cnt_q = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut_a.drop_cnt_q;
      exp_drop_cnt[0] = 32'hFFFF_FFFF;
      send_frame(0, 20, 8'd17, 16'd5000, MAGIC, 2'd0, 2'd0, 2, '1, 1'b0);
      drain(0);
      check_counts(0, "sat_a");
      in_a.tdata = make_hdr(21, 8'd17, 16'd5000, MAGIC);
      in_a.tkeep = '1; in_a.tlast = 1'b1; in_a.tvalid = 1'b1; clr_a = 1'b1;
      @(negedge clk);
      vectors++;
      if (!in_a.tready) begin
         miscompares++;
         $display("FAIL clr_tready: got 0 want 1");
      end
      @(posedge clk); #1;
      in_a.tvalid = 1'b0; in_a.tlast = 1'b0; clr_a = 1'b0;
      exp_pass_cnt[0] = '0;
      exp_drop_cnt[0] = '0;
      repeat (2) begin @(posedge clk); #1; end
      check_counts(0, "clear_a");
      send_frame(0, 22, 8'd17, 16'd32002, MAGIC, 2'd0, 2'd0, 3, '1, 1'b1);
      drain(0);
      check_counts(0, "post_clear_a");

      vectors++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: got a=%0d b=%0d pending, want 0", exp_a.size(), exp_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
